dma_job_scheduler: RTL and testbench

- Shares the single system DMA engine between NumReq requesters: the management core and the vicuna cores.
- Each requester owns a one-entry job slot (src, dst, len).
- A round-robin arbiter picks pending jobs and issues one at a time to the DMA over a valid/ready command port.
- The block waits for DMA completion and returns a per-requester done/error pulse.
- Sits between the core-side control registers and the DMA register programming path.

---
 rtl/dma_job_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_dma_job_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_job_scheduler.sv
// Round-robin scheduler sharing one DMA engine between NumReq requesters, each with a one-entry job slot.
// Optional WAIT watchdog with DMA abort enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_job_scheduler #(
  parameter int unsigned NumReq        = 3,
  parameter int unsigned AddrW         = 32,
  parameter int unsigned LenW          = 16,
  parameter int unsigned TimeoutCycles = 65535,
  localparam int unsigned IdxW = (NumReq > 2) ? $clog2(NumReq) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*AddrW-1:0] req_src_i,
  input  logic [NumReq*AddrW-1:0] req_dst_i,
  input  logic [NumReq*LenW-1:0]  req_len_i,
  output logic [NumReq-1:0]       done_valid_o,
  output logic [NumReq-1:0]       done_err_o,
  output logic                    dma_valid_o,
  input  logic                    dma_ready_i,
  output logic [AddrW-1:0]        dma_src_o,
  output logic [AddrW-1:0]        dma_dst_o,
  output logic [LenW-1:0]         dma_len_o,
  input  logic                    dma_done_i,
  input  logic                    dma_err_i,
  output logic                    dma_abort_o,
  output logic                    busy_o,
  output logic [IdxW-1:0]         owner_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [NumReq-1:0] empty_q;
  logic [AddrW-1:0]  src_q [NumReq];
  logic [AddrW-1:0]  dst_q [NumReq];
  logic [LenW-1:0]   len_q [NumReq];

  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   owner_q;
  logic [AddrW-1:0]  cmd_src_q;
  logic [AddrW-1:0]  cmd_dst_q;
  logic [LenW-1:0]   cmd_len_q;
  logic              err_q, err_d;

  logic              any_full;
  logic [IdxW-1:0]   gidx;
  logic              grant;
  logic              timeout_hit;

  // First full slot at or after the RR pointer, wrapping modulo NumReq.
  always_comb begin
    int unsigned cand;
    any_full = 1'b0;
    gidx     = '0;
    cand     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!any_full && !empty_q[cand]) begin
        any_full = 1'b1;
        gidx     = IdxW'(cand);
      end
    end
  end

`ifdef DMA_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] wait_cnt_q;

  // Counter sits at zero outside WAIT, so the first WAIT cycle sees 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    grant        = 1'b0;
    dma_valid_o  = 1'b0;
    dma_abort_o  = 1'b0;
    done_valid_o = '0;
    done_err_o   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_full) begin
          grant = 1'b1;
          if (len_q[gidx] != '0) begin
            state_d = ST_ISSUE;
            err_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        dma_valid_o = 1'b1;
        if (dma_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the timeout cycle takes priority over the abort.
        if (dma_done_i) begin
          state_d = ST_DONE;
          err_d   = dma_err_i;
        end else if (timeout_hit) begin
          dma_abort_o = 1'b1;
          state_d     = ST_DONE;
          err_d       = 1'b1;
        end
      end
      ST_DONE: begin
        done_valid_o[owner_q] = 1'b1;
        done_err_o[owner_q]   = err_q;
        state_d               = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      err_q     <= 1'b0;
      empty_q   <= '1;
      ptr_q     <= '0;
      owner_q   <= '0;
      cmd_src_q <= '0;
      cmd_dst_q <= '0;
      cmd_len_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (grant && (gidx == IdxW'(i))) begin
          empty_q[i] <= 1'b1;
        end else if (req_valid_i[i] && empty_q[i]) begin
          empty_q[i] <= 1'b0;
        end
      end
      if (grant) begin
        owner_q   <= gidx;
        cmd_src_q <= src_q[gidx];
        cmd_dst_q <= dst_q[gidx];
        cmd_len_q <= len_q[gidx];
      end
      if (state_q == ST_DONE) begin
        ptr_q <= (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

  // Slot payload needs no reset: it is only read while the slot is full.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (req_valid_i[i] && empty_q[i]) begin
        src_q[i] <= req_src_i[i*AddrW +: AddrW];
        dst_q[i] <= req_dst_i[i*AddrW +: AddrW];
        len_q[i] <= req_len_i[i*LenW +: LenW];
      end
    end
  end

  assign req_ready_o = empty_q;
  assign dma_src_o   = cmd_src_q;
  assign dma_dst_o   = cmd_dst_q;
  assign dma_len_o   = cmd_len_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Self-checking bench for dma_job_scheduler (NumReq = 3): vector table, command/done scoreboard
// and hand-written sequences for backpressure, reset mid-job, fairness and the watchdog.
module tb_dma_job_scheduler;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*AW-1:0] req_src_i;
  logic [N*AW-1:0] req_dst_i;
  logic [N*LW-1:0] req_len_i;
  logic [N-1:0]    done_valid_o;
  logic [N-1:0]    done_err_o;
  logic            dma_valid_o;
  logic            dma_ready_i;
  logic [AW-1:0]   dma_src_o;
  logic [AW-1:0]   dma_dst_o;
  logic [LW-1:0]   dma_len_o;
  logic            dma_done_i;
  logic            dma_err_i;
  logic            dma_abort_o;
  logic            busy_o;
  logic [1:0]      owner_o;

  always #5 clk = ~clk;

  dma_job_scheduler #(
    .NumReq       (N),
    .AddrW        (AW),
    .LenW         (LW),
    .TimeoutCycles(16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_src_i   (req_src_i),
    .req_dst_i   (req_dst_i),
    .req_len_i   (req_len_i),
    .done_valid_o(done_valid_o),
    .done_err_o  (done_err_o),
    .dma_valid_o (dma_valid_o),
    .dma_ready_i (dma_ready_i),
    .dma_src_o   (dma_src_o),
    .dma_dst_o   (dma_dst_o),
    .dma_len_o   (dma_len_o),
    .dma_done_i  (dma_done_i),
    .dma_err_i   (dma_err_i),
    .dma_abort_o (dma_abort_o),
    .busy_o      (busy_o),
    .owner_o     (owner_o)
  );

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } cmd_t;

  typedef struct {
    logic [2:0] vec;
    logic [2:0] err;
  } done_t;

  typedef struct {
    int          req;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          lat;
    logic        err;
    logic [2:0]  exp_vec;
    logic        exp_err;
  } vec_t;

  cmd_t  cmd_q[$];
  done_t done_q[$];

  int   checks = 0;
  int   errors = 0;

  // DMA responder state
  bit   pending = 0;
  int   cnt = 0;
  int   lat = 0;
  logic next_err = 1'b0;
  bit   force_done = 0;
  bit   hs_seen = 0;
  bit   abort_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample/score at negedge, then advance to just after the next posedge and drive the DMA model.
  task automatic step();
    cmd_t  ec;
    done_t ed;
    @(negedge clk);
    hs_seen = 0;
    if (dma_valid_o && dma_ready_i) begin
      hs_seen = 1;
      if (cmd_q.size() == 0) begin
        chk("unexpected_cmd", 128'(dma_valid_o), 128'(0));
      end else begin
        ec = cmd_q.pop_front();
        chk("cmd", 128'({owner_o, dma_src_o, dma_dst_o, dma_len_o}),
            128'({ec.owner, ec.src, ec.dst, ec.len}));
      end
      pending = 1;
      cnt     = lat;
    end
    if (done_valid_o != '0) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 128'(done_valid_o), 128'(0));
      end else begin
        ed = done_q.pop_front();
        chk("done_vec", 128'(done_valid_o), 128'(ed.vec));
        chk("done_err", 128'(done_err_o), 128'(ed.err));
      end
    end
    if (dma_abort_o) abort_seen = 1;
    @(posedge clk);
    #1;
    dma_done_i = 1'b0;
    dma_err_i  = 1'b0;
    if (force_done) begin
      dma_done_i = 1'b1;
      force_done = 0;
    end else if (pending) begin
      if (cnt == 0) begin
        dma_done_i = 1'b1;
        dma_err_i  = next_err;
        pending    = 0;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic drive_push(input int r, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    req_valid_i[r]          = 1'b1;
    req_src_i[r*AW +: AW]   = s;
    req_dst_i[r*AW +: AW]   = d;
    req_len_i[r*LW +: LW]   = l;
  endtask

  task automatic expect_job(input int r, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input logic e);
    cmd_t  c;
    done_t dn;
    logic [2:0] v;
    v = 3'b001 << r;
    if (l != 0) begin
      c.owner = 2'(r); c.src = s; c.dst = d; c.len = l;
      cmd_q.push_back(c);
    end
    dn.vec = v;
    dn.err = e ? v : 3'b000;
    done_q.push_back(dn);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (cmd_q.size() != 0 || done_q.size() != 0); i++) step();
    chk(name, 128'(cmd_q.size() + done_q.size()), 128'(0));
  endtask

  task automatic wait_handshake(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      step();
      if (hs_seen) break;
    end
    chk(name, 128'(hs_seen), 128'(1));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_ready"}, 128'(req_ready_o), 128'(3'b111));
    chk({name, "_done"}, 128'({done_valid_o, done_err_o}), 128'(0));
    chk({name, "_dma"}, 128'({dma_valid_o, dma_abort_o, dma_src_o, dma_dst_o, dma_len_o}), 128'(0));
    chk({name, "_busy_owner"}, 128'({busy_o, owner_o}), 128'(0));
  endtask

  vec_t vt[5];

  initial begin
    bit abort_early;
    vt[0] = '{1, 32'h0010_0000, 32'h0002_0000, 16'h0040, 0, 1'b0, 3'b010, 1'b0};
    vt[1] = '{0, 32'h0000_1000, 32'h0000_2000, 16'h0080, 3, 1'b1, 3'b001, 1'b1};
    vt[2] = '{2, 32'hAAAA_0000, 32'h5555_0000, 16'h0000, 0, 1'b0, 3'b100, 1'b1};
    vt[3] = '{2, 32'hDEAD_BEEC, 32'h1234_5678, 16'hFFFF, 5, 1'b0, 3'b100, 1'b0};
    vt[4] = '{0, 32'hFFFF_FFFC, 32'h0000_0000, 16'h0001, 1, 1'b0, 3'b001, 1'b0};

    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_src_i   = '0;
    req_dst_i   = '0;
    req_len_i   = '0;
    dma_ready_i = 1'b1;
    dma_done_i  = 1'b0;
    dma_err_i   = 1'b0;
    step();
    step();
    check_reset_state("reset");
    rst_ni = 1'b1;
    step();

    // Single jobs from the vector table, including latency to command and zero-length handling.
    foreach (vt[n]) begin
      lat      = vt[n].lat;
      next_err = vt[n].err;
      chk("ready_t0", 128'(req_ready_o[vt[n].req]), 128'(1));
      drive_push(vt[n].req, vt[n].src, vt[n].dst, vt[n].len);
      expect_job(vt[n].req, vt[n].src, vt[n].dst, vt[n].len, vt[n].exp_err);
      step();
      req_valid_i = '0;
      chk("full_t1", 128'(req_ready_o[vt[n].req]), 128'(0));
      chk("no_valid_t1", 128'(dma_valid_o), 128'(0));
      step();
      chk("ready_t2", 128'(req_ready_o[vt[n].req]), 128'(1));
      if (vt[n].len != 0) begin
        chk("valid_t2", 128'(dma_valid_o), 128'(1));
      end else begin
        chk("zlen_valid_t2", 128'(dma_valid_o), 128'(0));
        chk("zlen_done_t2", 128'({done_valid_o, done_err_o}), 128'({vt[n].exp_vec, vt[n].exp_vec}));
      end
      drain("vec_drain");
    end

    // Backpressure: payload held while ready is low, dma_done_i ignored in ISSUE.
    dma_ready_i = 1'b0;
    lat         = 0;
    next_err    = 1'b0;
    drive_push(0, 32'hCAFE_0000, 32'hBEEF_0000, 16'h0100);
    expect_job(0, 32'hCAFE_0000, 32'hBEEF_0000, 16'h0100, 1'b0);
    step();
    req_valid_i = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", 128'({dma_valid_o, dma_src_o, dma_dst_o, dma_len_o}),
          128'({1'b1, 32'hCAFE_0000, 32'hBEEF_0000, 16'h0100}));
      if (k == 2) force_done = 1;
      step();
    end
    chk("bp_still_issue", 128'({dma_valid_o, busy_o}), 128'(2'b11));
    dma_ready_i = 1'b1;
    step();
    chk("bp_wait", 128'({dma_valid_o, busy_o, dma_done_i}), 128'(3'b011));
    step();
    chk("done_d_plus_1", 128'(done_valid_o), 128'(3'b001));
    drain("bp_drain");

    // Reset in WAIT drops the job without a completion pulse.
    lat = 1000;
    drive_push(1, 32'h0000_4000, 32'h0000_8000, 16'h0020);
    cmd_q.push_back('{2'd1, 32'h0000_4000, 32'h0000_8000, 16'h0020});
    step();
    req_valid_i = '0;
    wait_handshake("rst_hs");
    step();
    chk("rst_in_wait", 128'({busy_o, dma_valid_o}), 128'(2'b10));
    rst_ni = 1'b0;
    step();
    rst_ni  = 1'b1;
    pending = 0;
    check_reset_state("midjob_reset");
    for (int k = 0; k < 5; k++) step();

    // Fairness from pointer 0 with a zero-wait DMA.
    lat = 0;
    for (int r = 0; r < 3; r++) begin
      drive_push(r, 32'h100 * (r + 1), 32'h200 * (r + 1), 16'(8 * (r + 1)));
      expect_job(r, 32'h100 * (r + 1), 32'h200 * (r + 1), 16'(8 * (r + 1)), 1'b0);
    end
    step();
    req_valid_i = '0;
    chk("all_full", 128'(req_ready_o), 128'(3'b000));
    drain("rr_round1");
    drive_push(0, 32'h0000_0A00, 32'h0000_0B00, 16'h0004);
    drive_push(2, 32'h0000_0C00, 32'h0000_0D00, 16'h0006);
    expect_job(0, 32'h0000_0A00, 32'h0000_0B00, 16'h0004, 1'b0);
    expect_job(2, 32'h0000_0C00, 32'h0000_0D00, 16'h0006, 1'b0);
    step();
    req_valid_i = '0;
    drain("rr_round2");

`ifdef DMA_SCHED_TIMEOUT_EN
    // Watchdog: abort on the 16th WAIT cycle, then error completion; late done ignored.
    lat = 100000;
    drive_push(2, 32'h0003_0000, 32'h0004_0000, 16'h0010);
    expect_job(2, 32'h0003_0000, 32'h0004_0000, 16'h0010, 1'b1);
    step();
    req_valid_i = '0;
    wait_handshake("to_hs");
    abort_early = 0;
    for (int k = 1; k < 16; k++) begin
      if (dma_abort_o) abort_early = 1;
      step();
    end
    chk("no_early_abort", 128'(abort_early), 128'(0));
    chk("abort_16", 128'({dma_abort_o, busy_o}), 128'(2'b11));
    step();
    chk("to_done", 128'({done_valid_o, done_err_o}), 128'({3'b100, 3'b100}));
    chk("abort_pulse", 128'(dma_abort_o), 128'(0));
    pending    = 0;
    force_done = 1;
    step();
    for (int k = 0; k < 4; k++) step();
    chk("late_done_idle", 128'({busy_o, req_ready_o}), 128'(4'b0111));
    drain("to_drain");
`else
    abort_seen = 0;
    lat        = 30;
    drive_push(1, 32'h0005_0000, 32'h0006_0000, 16'h0200);
    expect_job(1, 32'h0005_0000, 32'h0006_0000, 16'h0200, 1'b0);
    step();
    req_valid_i = '0;
    drain("long_wait_drain");
    chk("no_abort", 128'(abort_seen), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
